// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative signed multiply/divide unit with its own sequencing FSM
//
// Purpose: computes a signed WIDTH x WIDTH product or a signed quotient/remainder
// one bit per cycle and presents the result as HI/LO for the CPU's HI/LO registers.
// The quotient truncates toward zero. The remainder takes the sign of the dividend.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous, active-high reset
//   i_start        request, sampled only while idle
//   i_op           0 = divide, 1 = multiply
//   i_a            multiplicand / dividend, two's complement
//   i_b            multiplier / divisor, two's complement
//   o_busy         high in every state except idle
//   o_done         one-cycle completion pulse
//   o_div_by_zero  high with o_done for a divide by zero
//   o_hi           product upper half, or remainder
//   o_lo           product lower half, or quotient
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic             r_sign;
    logic             r_a_sign;
    logic [CNT_W-1:0] r_cnt;
    // Mult: P_hi / P_lo.  Div: remainder R / quotient Q.
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_mul_addend;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_rsh;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    // Negating the most negative value wraps back onto itself, which read as
    // unsigned is exactly its magnitude 2^(WIDTH-1).
    assign w_mag_a = r_a[WIDTH-1] ? (~r_a + 1'b1) : r_a;
    assign w_mag_b = r_b[WIDTH-1] ? (~r_b + 1'b1) : r_b;

    // Shift-add step: the carry out of P_hi + |a| exists only transiently and
    // is shifted straight back into P_hi.
    assign w_mul_addend = r_acc_lo[0] ? r_mag_a : '0;
    assign w_mul_sum    = {1'b0, r_acc_hi} + {1'b0, w_mul_addend};

    // Restoring step on the WIDTH+1 bit shifted remainder. The stored remainder
    // is always below |b| <= 2^(WIDTH-1), so WIDTH bits suffice between steps.
    assign w_div_rsh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_diff = w_div_rsh - {1'b0, r_mag_b};
    assign w_div_ge   = (w_div_rsh >= {1'b0, r_mag_b});

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_neg = ~w_prod + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_op          <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_mag_a       <= '0;
            r_mag_b       <= '0;
            r_sign        <= 1'b0;
            r_a_sign      <= 1'b0;
            r_cnt         <= '0;
            r_acc_hi      <= '0;
            r_acc_lo      <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
            o_hi          <= '0;
            o_lo          <= '0;
        end else begin
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op    <= i_op;
                        r_a     <= i_a;
                        r_b     <= i_b;
                        o_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_mag_a  <= w_mag_a;
                    r_mag_b  <= w_mag_b;
                    r_sign   <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                    r_a_sign <= r_a[WIDTH-1];
                    r_cnt    <= '0;
                    r_acc_hi <= '0;
                    r_acc_lo <= r_op ? w_mag_b : w_mag_a;
                    if (!r_op && (r_b == '0)) begin
                        // Skip the iterations; HI/LO keep their previous result.
                        o_done        <= 1'b1;
                        o_div_by_zero <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_op) begin
                        r_acc_hi <= w_mul_sum[WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end else begin
                        r_acc_hi <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_rsh[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ge};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_op) begin
                        {o_hi, o_lo} <= r_sign ? w_prod_neg : w_prod;
                    end else begin
                        o_lo <= r_sign   ? (~r_acc_lo + 1'b1) : r_acc_lo;
                        o_hi <= r_a_sign ? (~r_acc_hi + 1'b1) : r_acc_hi;
                    end
                    o_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
